// File: rtl/incr_share_arbiter_pkg.sv
// Shared definitions for the incr_share_arbiter slice.
//   - state_t   : FSM state encoding (IDLE/EXEC/WB). Encoding 2'd3 is illegal
//                 and is steered back to IDLE by the FSM.
//   - CNT_W     : per-channel count width, fixed by the shared incrementer.
//   - incrementer4bit : ripple incrementer, CNT_W-bit operand to CNT_W+1-bit
//                 result. The MSB of the result is the carry-out (wrap).
package incr_share_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Ripple-carry +1: the carry-in is the constant one, each stage passes
   // its carry to the next. Result bit CNT_W is the final carry-out.
   function automatic logic [CNT_W:0] incrementer4bit(input logic [CNT_W-1:0] a);
      logic             carry;
      logic [CNT_W:0]   res;
      carry = 1'b1;
      res   = '0;
      for (int i = 0; i < CNT_W; i++) begin
         res[i] = a[i] ^ carry;
         carry  = a[i] & carry;
      end
      res[CNT_W] = carry;
      return res;
   endfunction

endpackage

// File: rtl/incr_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Ports:
//   pending [NUM_REQ-1:0] in  : channels with a queued request
//   ptr     [IDX_W-1:0]   in  : channel searched first (always < NUM_REQ)
//   onehot  [NUM_REQ-1:0] out : one-hot winner (0 when nothing pending)
//   idx     [IDX_W-1:0]   out : winner index (0 when nothing pending)
//   valid               out : a winner exists
// The search starts at ptr and wraps, so the first set bit at or after ptr
// wins. A lone pending bit therefore wins regardless of ptr.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum_s;
   logic [IDX_W-1:0] pos_s;

   // Scan channels in rotated order, keep the first pending one found.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      sum_s  = '0;
      pos_s  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum_s = {1'b0, ptr} + SUM_W'(off);
         if (sum_s >= SUM_W'(NUM_REQ)) begin
            sum_s = sum_s - SUM_W'(NUM_REQ);
         end else begin
            sum_s = sum_s;
         end
         pos_s = sum_s[IDX_W-1:0];
         if (!valid && pending[pos_s]) begin
            valid          = 1'b1;
            idx            = pos_s;
            onehot[pos_s]  = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/incr_share_arbiter.sv
// incr_share_arbiter: NUM_REQ channels share one 4-bit incrementer.
// Each channel owns a count register and a sticky overflow flag. Requests are
// queued in a pending vector and serviced one at a time, round robin, in a
// three-cycle IDLE -> EXEC -> WB sequence.
// Ports:
//   clk       in  1           clock, all state on posedge
//   rst       in  1           synchronous active-high reset (aborts any service)
//   req       in  NUM_REQ     1-cycle pulse per channel: request one increment
//   clr       in  NUM_REQ     per-channel sync clear of count and overflow
//   grant     out NUM_REQ     one-hot channel in service, valid EXEC..WB
//   done      out 1           high during the write-back cycle
//   busy      out 1           high in EXEC and WB
//   cnt_flat  out 4*NUM_REQ   channel i count on bits [4i+3:4i]
//   ovf       out NUM_REQ     sticky wrap flag per channel (15 -> 0)
module incr_share_arbiter
   import incr_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       clr,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     done,
   output logic                     busy,
   output logic [CNT_W*NUM_REQ-1:0] cnt_flat,
   output logic [NUM_REQ-1:0]       ovf
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               state_r, state_n;
   logic [NUM_REQ-1:0]   pending_r, pending_n;
   logic [NUM_REQ-1:0]   grant_r, grant_n;
   logic [IDX_W-1:0]     winner_r, winner_n;
   logic [IDX_W-1:0]     ptr_r, ptr_n;
   logic [CNT_W:0]       res_q_r;
   logic [CNT_W-1:0]     cnt_r [NUM_REQ];
   logic [NUM_REQ-1:0]   ovf_r;
   logic                 done_r;
   logic                 busy_r;
   logic                 wb_s;

   logic [NUM_REQ-1:0]   pick_onehot_s;
   logic [IDX_W-1:0]     pick_idx_s;
   logic                 pick_valid_s;
   logic [CNT_W-1:0]     operand_s;
   logic [CNT_W:0]       inc_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .pending (pending_r),
      .ptr     (ptr_r),
      .onehot  (pick_onehot_s),
      .idx     (pick_idx_s),
      .valid   (pick_valid_s)
   );

   // Single shared incrementer, fed by a mux over the channel counts.
   always_comb begin
      operand_s = cnt_r[winner_r];
      inc_s     = incrementer4bit(operand_s);
   end

   // Next-state and next-value logic of the service FSM.
   always_comb begin
      state_n  = state_r;
      grant_n  = grant_r;
      winner_n = winner_r;
      ptr_n    = ptr_r;
      wb_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               grant_n  = pick_onehot_s;
               winner_n = pick_idx_s;
               state_n  = ST_EXEC;
            end else begin
               state_n  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_n = ST_WB;
         end
         ST_WB: begin
            wb_s    = 1'b1;
            grant_n = '0;
            state_n = ST_IDLE;
            if (winner_r == IDX_W'(NUM_REQ - 1)) begin
               ptr_n = '0;
            end else begin
               ptr_n = winner_r + IDX_W'(1);
            end
         end
         default: begin
            grant_n = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // Pending queue: write-back clears the serviced bit, but a request in the
   // same cycle re-arms it (the OR with req comes last).
   always_comb begin
      if (wb_s) begin
         pending_n = (pending_r & ~grant_r) | req;
      end else begin
         pending_n = pending_r | req;
      end
   end

   // FSM state, arbitration registers and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pending_r <= '0;
         grant_r   <= '0;
         winner_r  <= '0;
         ptr_r     <= '0;
         res_q_r   <= '0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_n;
         pending_r <= pending_n;
         grant_r   <= grant_n;
         winner_r  <= winner_n;
         ptr_r     <= ptr_n;
         if (state_r == ST_EXEC) begin
            res_q_r <= inc_s;
         end else begin
            res_q_r <= res_q_r;
         end
         // done/busy are computed from the next state so they line up with
         // the state they describe without a decode after the register.
         done_r    <= (state_n == ST_WB);
         busy_r    <= (state_n == ST_EXEC) || (state_n == ST_WB);
      end
   end

   // Per-channel counts and sticky overflow; a clear beats a same-cycle write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_r[i] <= '0;
         end
         ovf_r <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (clr[i]) begin
               cnt_r[i] <= '0;
               ovf_r[i] <= 1'b0;
            end else if (wb_s && (winner_r == IDX_W'(i))) begin
               cnt_r[i] <= res_q_r[CNT_W-1:0];
               if (res_q_r[CNT_W]) begin
                  ovf_r[i] <= 1'b1;
               end else begin
                  ovf_r[i] <= ovf_r[i];
               end
            end else begin
               cnt_r[i] <= cnt_r[i];
               ovf_r[i] <= ovf_r[i];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_flat
         assign cnt_flat[CNT_W*g +: CNT_W] = cnt_r[g];
      end
   endgenerate

   assign grant = grant_r;
   assign done  = done_r;
   assign busy  = busy_r;
   assign ovf   = ovf_r;

endmodule
